// File: rtl/popcount_serial.sv
// Multi-cycle population counter: counts set (or clear) bits of a WIDTH-bit
// word CHUNK bits per clock behind valid/ready handshakes on both sides.
module popcount_serial #(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int OUT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_invert,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_count
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W  = $clog2(CHUNK + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    generate
        if (WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $error("popcount_serial: CHUNK must divide WIDTH, WIDTH >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [PC_W-1:0]  chunk_cnt;

    // One shared adder tree over the low chunk of the shift register.
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + PC_W'(shift_q[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_invert ? ~in_data : in_data;
                    acc_d   = '0;
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d   = acc_q + OUT_W'(chunk_cnt);
                shift_d = shift_q >> CHUNK;
                beat_d  = beat_q + 1'b1;
                if (beat_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            acc_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            beat_q  <= beat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_count = acc_q;

endmodule

// File: tb/tb_popcount_serial.sv
// Directed bench for popcount_serial in three configurations:
// 32/8, 8/2 (exhaustive) and 16/16 (single beat).
module tb_popcount_serial;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic        a_iv, a_ir, a_inv, a_ov, a_or;
    logic [31:0] a_d;
    logic [5:0]  a_cnt;

    logic        b_iv, b_ir, b_inv, b_ov, b_or;
    logic [7:0]  b_d;
    logic [3:0]  b_cnt;

    logic        c_iv, c_ir, c_inv, c_ov, c_or;
    logic [15:0] c_d;
    logic [4:0]  c_cnt;

    popcount_serial #(.WIDTH(32), .CHUNK(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_d), .in_invert(a_inv),
        .out_valid(a_ov), .out_ready(a_or),
        .out_count(a_cnt)
    );

    popcount_serial #(.WIDTH(8), .CHUNK(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_d), .in_invert(b_inv),
        .out_valid(b_ov), .out_ready(b_or),
        .out_count(b_cnt)
    );

    popcount_serial #(.WIDTH(16), .CHUNK(16)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_d), .in_invert(c_inv),
        .out_valid(c_ov), .out_ready(c_or),
        .out_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus tasks are entered and left at a falling edge.
    task automatic start_a(input logic [31:0] d, input logic inv);
        a_d = d; a_inv = inv; a_iv = 1'b1;
        @(negedge clk);
        a_iv = 1'b0;
    endtask

    task automatic wait_a(output int lat);
        lat = 0;
        while (!a_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_a();
        a_or = 1'b1;
        @(negedge clk);
        a_or = 1'b0;
    endtask

    task automatic start_b(input logic [7:0] d, input logic inv);
        b_d = d; b_inv = inv; b_iv = 1'b1;
        @(negedge clk);
        b_iv = 1'b0;
    endtask

    task automatic wait_b(output int lat);
        lat = 0;
        while (!b_ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop_b();
        b_or = 1'b1;
        @(negedge clk);
        b_or = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_iv = 0; a_or = 0; a_d = '0; a_inv = 0;
        b_iv = 0; b_or = 0; b_d = '0; b_inv = 0;
        c_iv = 0; c_or = 0; c_d = '0; c_inv = 0;
        repeat (2) @(negedge clk);
        total++;
        if (a_ir !== 1'b1) begin
            bad++; $display("FAIL rst_a_ready got=%b want=1", a_ir);
        end
        total++;
        if (a_ov !== 1'b0) begin
            bad++; $display("FAIL rst_a_valid got=%b want=0", a_ov);
        end
        total++;
        if (a_cnt !== 6'd0) begin
            bad++; $display("FAIL rst_a_count got=%0d want=0", a_cnt);
        end
        total++;
        if (b_ir !== 1'b1 || b_ov !== 1'b0 || b_cnt !== 4'd0) begin
            bad++;
            $display("FAIL rst_b got=%b/%b/%0d want=1/0/0", b_ir, b_ov, b_cnt);
        end
        total++;
        if (c_ir !== 1'b1 || c_ov !== 1'b0 || c_cnt !== 5'd0) begin
            bad++;
            $display("FAIL rst_c got=%b/%b/%0d want=1/0/0", c_ir, c_ov, c_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] d [3];
        int          e [3];
        int          lat;
        d[0] = 32'h0000_0000; e[0] = 0;
        d[1] = 32'hFFFF_FFFF; e[1] = 32;
        d[2] = 32'hF0F0_0001; e[2] = 9;
        for (int i = 0; i < 3; i++) begin
            start_a(d[i], 1'b0);
            wait_a(lat);
            total++;
            if (lat !== 4) begin
                bad++; $display("FAIL basic_lat%0d got=%0d want=4", i, lat);
            end
            total++;
            if (a_cnt !== e[i][5:0]) begin
                bad++;
                $display("FAIL basic_cnt%0d got=%0d want=%0d", i, a_cnt, e[i]);
            end
            pop_a();
            total++;
            if (a_ir !== 1'b1 || a_ov !== 1'b0) begin
                bad++;
                $display("FAIL basic_idle%0d got=%b/%b want=1/0", i, a_ir, a_ov);
            end
        end
    endtask

    task automatic test_invert();
        int lat;
        start_a(32'h0000_00FF, 1'b1);
        wait_a(lat);
        total++;
        if (a_cnt !== 6'd24 || lat !== 4) begin
            bad++;
            $display("FAIL inv_on got=%0d lat=%0d want=24 lat=4", a_cnt, lat);
        end
        pop_a();
        start_a(32'h0000_00FF, 1'b0);
        wait_a(lat);
        total++;
        if (a_cnt !== 6'd8) begin
            bad++; $display("FAIL inv_off got=%0d want=8", a_cnt);
        end
        pop_a();
    endtask

    task automatic test_backpressure();
        int lat;
        start_a(32'hF0F0_0001, 1'b0);
        wait_a(lat);
        for (int i = 0; i < 5; i++) begin
            a_iv  = (i % 2 == 0);
            a_d   = $urandom;
            a_inv = 1'b1;
            @(negedge clk);
            total++;
            if (a_ov !== 1'b1 || a_ir !== 1'b0 || a_cnt !== 6'd9) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%b/%0d want=1/0/9",
                         i, a_ov, a_ir, a_cnt);
            end
        end
        a_iv = 1'b0;
        pop_a();
        total++;
        if (a_ir !== 1'b1) begin
            bad++; $display("FAIL bp_release got=%b want=1", a_ir);
        end
        start_a(32'h0000_00F0, 1'b0);
        total++;
        if (a_ir !== 1'b0) begin
            bad++; $display("FAIL bp_next_accept got=%b want=0", a_ir);
        end
        wait_a(lat);
        total++;
        if (a_cnt !== 6'd4 || lat !== 4) begin
            bad++;
            $display("FAIL bp_next_cnt got=%0d lat=%0d want=4 lat=4", a_cnt, lat);
        end
        pop_a();
    endtask

    task automatic test_reset_mid();
        int lat;
        start_a(32'hFFFF_FFFF, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1 || a_cnt !== 6'd0) begin
            bad++;
            $display("FAIL midrst got=%b/%b/%0d want=0/1/0", a_ov, a_ir, a_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (a_ov !== 1'b0 || a_ir !== 1'b1) begin
            bad++; $display("FAIL midrst_quiet got=%b/%b want=0/1", a_ov, a_ir);
        end
        start_a(32'h0000_0003, 1'b0);
        wait_a(lat);
        total++;
        if (a_cnt !== 6'd2 || lat !== 4) begin
            bad++;
            $display("FAIL midrst_next got=%0d lat=%0d want=2 lat=4", a_cnt, lat);
        end
        pop_a();
    endtask

    task automatic test_exhaustive_small();
        int lat;
        int exp;
        logic [7:0] v;
        for (int inv = 0; inv < 2; inv++) begin
            for (int x = 0; x < 256; x++) begin
                v = x[7:0];
                exp = 0;
                for (int k = 0; k < 8; k++) begin
                    exp += (inv != 0) ? int'(!v[k]) : int'(v[k]);
                end
                start_b(v, inv[0]);
                wait_b(lat);
                total++;
                if (b_cnt !== exp[3:0] || lat !== 4) begin
                    bad++;
                    $display("FAIL small x=%02h inv=%0d got=%0d lat=%0d want=%0d lat=4",
                             v, inv, b_cnt, lat, exp);
                end
                pop_b();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [3];
        int          e [3];
        int          t [3];
        int          idx;
        int          got;
        int          lat;
        c_d = 16'hAAAA; c_inv = 1'b0; c_iv = 1'b1;
        @(negedge clk);
        c_iv = 1'b0;
        lat = 0;
        while (!c_ov && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (c_cnt !== 5'd8 || lat !== 1) begin
            bad++;
            $display("FAIL single got=%0d lat=%0d want=8 lat=1", c_cnt, lat);
        end
        c_or = 1'b1;
        @(negedge clk);
        w[0] = 16'h0001; e[0] = 1;
        w[1] = 16'hFFFF; e[1] = 16;
        w[2] = 16'h0F0F; e[2] = 8;
        idx = 0;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
            if (c_ov) begin
                t[got] = cyc;
                total++;
                if (c_cnt !== e[got][4:0]) begin
                    bad++;
                    $display("FAIL b2b_cnt%0d got=%0d want=%0d", got, c_cnt, e[got]);
                end
                got++;
            end
            if (c_ir && idx < 3) begin
                c_d = w[idx]; c_iv = 1'b1; idx++;
            end else begin
                c_iv = 1'b0;
            end
            @(negedge clk);
        end
        c_iv = 1'b0;
        c_or = 1'b0;
        total++;
        if (got !== 3) begin
            bad++; $display("FAIL b2b_results got=%0d want=3", got);
        end else begin
            total++;
            if (t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin
                bad++;
                $display("FAIL b2b_period got=%0d,%0d want=3,3",
                         t[1] - t[0], t[2] - t[1]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_invert();
        test_backpressure();
        test_reset_mid();
        test_exhaustive_small();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
